// File: rtl/fmul_seq_pkg.sv
// Shared types and defaults for the sequential single-precision multiplier.
// Optional feature macro: FMUL_SEQ_ZERO_BYPASS_EN (consumed by fmul_seq_ctrl).
package fmul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_EXP_WIDTH = 8;
  localparam int DEF_MAN_WIDTH = 23;
  localparam int DEF_EXP_BIAS  = 127;
  localparam int FP_WIDTH      = 1 + DEF_EXP_WIDTH + DEF_MAN_WIDTH;

  // Smallest w with 2**w >= n, used to size the iteration counter.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/fmul_seq_ctrl_mant_iter.sv
// Shift-add mantissa multiplier: one multiplier bit consumed per step.
// Only the upper MAN_WIDTH+2 product bits leave the block; the rest are
// always truncated by the normaliser, so they are never exported.
module fmul_mant_iter
  import fmul_seq_pkg::*;
#(
  parameter int MAN_WIDTH = DEF_MAN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 zero_i,
  input  logic                 step_i,
  input  logic [MAN_WIDTH-1:0] man_a_i,
  input  logic [MAN_WIDTH-1:0] man_b_i,
  output logic [MAN_WIDTH+1:0] prodHi_o
);

  localparam int N = MAN_WIDTH + 1;

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [N:0]     sum;

  // Load the multiplier into the low half, or add the multiplicand into the
  // top half when the current low bit is set, then shift right by one.
  always_comb begin
    acc_d = acc_q;
    sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, 1'b1, man_a_i};
    if (load_i) begin
      acc_d = zero_i ? '0 : {{N{1'b0}}, 1'b1, man_b_i};
    end else if (step_i) begin
      if (acc_q[0]) begin
        acc_d = {sum, acc_q[N-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*N-1:1]};
      end
    end
  end

  // Accumulator register, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign prodHi_o = acc_q[2*N-1:N-1];

endmodule

// File: rtl/fmul_seq_ctrl.sv
// Sequencing controller for a single-precision FP multiply: handshake in,
// iterative mantissa product, normalise/truncate, handshake out.
// Optional feature macro: FMUL_SEQ_ZERO_BYPASS_EN (zero operands skip MUL).
module fmul_seq_ctrl
  import fmul_seq_pkg::*;
#(
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int MAN_WIDTH = DEF_MAN_WIDTH,
  parameter int EXP_BIAS  = DEF_EXP_BIAS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_res,
  output logic                           out_ovf,
  output logic                           out_unf,
  output logic                           busy
);

  localparam int FW    = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int CNT_W = cnt_width(MAN_WIDTH + 2);
  localparam int EW2   = EXP_WIDTH + 2;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic [EXP_WIDTH-1:0]   expA_q, expA_d;
  logic [EXP_WIDTH-1:0]   expB_q, expB_d;
  logic [MAN_WIDTH-1:0]   manA_q, manA_d;
  logic                   zero_q, zero_d;
  logic [FW-1:0]          res_q, res_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic                   load;
  logic                   step;
  logic                   opZero;
  logic [MAN_WIDTH+1:0]   prodHi;
  logic [MAN_WIDTH-1:0]   normMan;
  logic [EW2-1:0]         expRaw;
  logic                   ovfHit;
  logic                   unfHit;

  fmul_mant_iter #(
    .MAN_WIDTH (MAN_WIDTH)
  ) u_mant_iter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .zero_i   (opZero),
    .step_i   (step),
    .man_a_i  (manA_q),
    .man_b_i  (in_b[MAN_WIDTH-1:0]),
    .prodHi_o (prodHi)
  );

  // Next-state, operand capture and result formatting; a product carry
  // selects the higher mantissa window and bumps the exponent by one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    expA_d  = expA_q;
    expB_d  = expB_q;
    manA_d  = manA_q;
    zero_d  = zero_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    load    = 1'b0;
    step    = 1'b0;
    opZero  = (in_a[FW-2 -: EXP_WIDTH] == '0) || (in_b[FW-2 -: EXP_WIDTH] == '0);
    normMan = prodHi[MAN_WIDTH+1] ? prodHi[MAN_WIDTH:1] : prodHi[MAN_WIDTH-1:0];
    expRaw  = EW2'(expA_q) + EW2'(expB_q) + EW2'(prodHi[MAN_WIDTH+1]) - EW2'(EXP_BIAS);
    ovfHit  = !expRaw[EW2-1] && (expRaw >= EW2'((1 << EXP_WIDTH) - 1));
    unfHit  = expRaw[EW2-1] || (expRaw == '0);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load   = 1'b1;
          sign_d = in_a[FW-1] ^ in_b[FW-1];
          expA_d = in_a[FW-2 -: EXP_WIDTH];
          expB_d = in_b[FW-2 -: EXP_WIDTH];
          manA_d = in_a[MAN_WIDTH-1:0];
          zero_d = opZero;
          cnt_d  = CNT_W'(MAN_WIDTH);
`ifdef FMUL_SEQ_ZERO_BYPASS_EN
          state_d = opZero ? NORM : MUL;
`else
          state_d = MUL;
`endif
        end
      end
      MUL: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      NORM: begin
        state_d = DONE;
        if (zero_q) begin
          res_d = {sign_q, {(FW-1){1'b0}}};
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end else if (ovfHit) begin
          res_d = {sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
          ovf_d = 1'b1;
          unf_d = 1'b0;
        end else if (unfHit) begin
          res_d = {sign_q, {(FW-1){1'b0}}};
          ovf_d = 1'b0;
          unf_d = 1'b1;
        end else begin
          res_d = {sign_q, expRaw[EXP_WIDTH-1:0], normMan};
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      expA_q  <= '0;
      expB_q  <= '0;
      manA_q  <= '0;
      zero_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      expA_q  <= expA_d;
      expB_q  <= expB_d;
      manA_q  <= manA_d;
      zero_q  <= zero_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// Self-checking bench for fmul_seq_ctrl: directed cases plus randomized
// operands compared against an arithmetic reference model.
module tb_fmul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_ovf;
  logic        out_unf;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  fmul_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of the significands, then truncate.
  // Returns {unf, ovf, result}.
  function automatic logic [33:0] refMul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea;
    int          eb;
    int          e;
    longint      ma;
    longint      mb;
    longint      p;
    logic [22:0] m;
    int          c;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {2'b00, s, 31'd0};
    ma = longint'(a[22:0]) + (longint'(1) << 23);
    mb = longint'(b[22:0]) + (longint'(1) << 23);
    p  = ma * mb;
    c  = (p >= (longint'(1) << 47)) ? 1 : 0;
    m  = (c == 1) ? 23'(p >> 24) : 23'(p >> 23);
    e  = ea + eb - 127 + c;
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b10, s, 31'd0};
    return {2'b00, s, 8'(e), m};
  endfunction

  // Accept-cycle-inclusive latency: 26 normally, 2 for bypassed zero operands.
  function automatic int expLatency(input logic [31:0] a, input logic [31:0] b);
`ifdef FMUL_SEQ_ZERO_BYPASS_EN
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 2;
`endif
    return 26;
  endfunction

  // One full transaction: offer a pair, measure latency, check result,
  // optionally stall the consumer while a new pair is waiting, then retire.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic expOvf,
                               input logic expUnf, input int hold, input string tag);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".inReady"}, 64'(in_ready), 64'(1));
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 64'(lat), 64'(expLatency(a, b)));
    checkOutput({tag, ".res"}, 64'(out_res), 64'(expRes));
    checkOutput({tag, ".ovf"}, 64'(out_ovf), 64'(expOvf));
    checkOutput({tag, ".unf"}, 64'(out_unf), 64'(expUnf));
    if (hold > 0) begin
      in_a     = $urandom();
      in_b     = $urandom();
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        checkOutput({tag, ".holdRes"}, 64'(out_res), 64'(expRes));
        checkOutput({tag, ".holdFlags"}, 64'({out_ovf, out_unf}), 64'({expOvf, expUnf}));
        checkOutput({tag, ".holdValid"}, 64'(out_valid), 64'(1));
        checkOutput({tag, ".holdInReady"}, 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, ".retired"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  // Random operand with a biased exponent so zero, overflow and underflow occur.
  function automatic logic [31:0] randOperand();
    int          mode;
    logic [7:0]  e;
    mode = int'($urandom_range(0, 5));
    case (mode)
      0:       e = 8'd0;
      1:       e = 8'($urandom_range(200, 255));
      2:       e = 8'($urandom_range(1, 50));
      default: e = 8'($urandom_range(90, 160));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom())};
  endfunction

  // Main sequence: reset, directed cases, mid-flight reset, random sweep.
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [33:0] expv;
    int          seen;

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h3FC00000;
    in_b      = 32'h40000000;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("reset.state", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    checkOutput("reset.res", 64'(out_res), 64'(0));
    checkOutput("reset.flags", 64'({out_ovf, out_unf}), 64'(0));

    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 0, "mul1p5x2");
    applyStimulus(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 0, "carry");
    applyStimulus(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 0, "sign");
    applyStimulus(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 0, "trunc");
    applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 0, "ovf");
    applyStimulus(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 0, "unf");
    applyStimulus(32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 1'b0, 0, "zero");
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 5, "stall");

    @(negedge clk);
    in_a     = 32'h3FC00000;
    in_b     = 32'h3FC00000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midReset.state", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    checkOutput("midReset.res", 64'(out_res), 64'(0));
    rst      = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    checkOutput("midReset.noValid", 64'(seen), 64'(0));
    applyStimulus(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 0, "afterReset");

    for (int i = 0; i < 24; i++) begin
      a    = randOperand();
      b    = randOperand();
      expv = refMul(a, b);
      applyStimulus(a, b, expv[31:0], expv[32], expv[33], (i % 3 == 0) ? 2 : 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
